// File: rtl/sha256_w_expander_param.sv
// SHA-256 message-schedule expander, WPC words per beat.
// Accepts one 512-bit block and streams W[0..ROUNDS-1] over a valid/ready
// interface.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   load_valid   block_in is valid
//   load_ready   block is accepted on load_valid && load_ready (high only in IDLE)
//   block_in     message block, [511:480] = W[0] ... [31:0] = W[15]
//   abort        synchronous abandon of the block being streamed
//   w_valid      w_out holds valid words (high only in RUN)
//   w_ready      consumer accepts the beat on w_valid && w_ready
//   w_out        W[t..t+WPC-1], W[t] in the MSBs, driven straight from the window registers
//   w_round      index t of the word in the MSBs of w_out
//   done         one-cycle pulse after the last beat of a block transfers
module sha256_w_expander_param #(
  parameter int unsigned WPC    = 1,
  parameter int unsigned ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [511:0]      block_in,
  input  logic              abort,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [32*WPC-1:0] w_out,
  output logic [5:0]        w_round,
  output logic              done
);

  if (!((WPC == 1 || WPC == 2 || WPC == 4) &&
        ROUNDS >= 16 && ROUNDS <= 64 && (ROUNDS % WPC) == 0)) begin : g_bad_params
    $error("sha256_w_expander_param: illegal WPC/ROUNDS combination");
  end

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - WPC);
  localparam logic [5:0] STEP   = 6'(WPC);

  state_t      state, state_n;
  logic [31:0] win   [16];
  logic [31:0] win_n [16];
  logic [31:0] ext   [16+WPC];
  logic [5:0]  t, t_n;
  logic        done_n;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Extended window: entries 16.. are the new words. Entry 16+k reads
  // entry 14+k, so for WPC > 1 the words produced this cycle feed the
  // later ones through the W[j-2] term, exactly as in a serial schedule.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      ext[i] = win[i];
    end
    for (int unsigned k = 0; k < WPC; k++) begin
      ext[16+k] = sig1(ext[14+k]) + ext[9+k] + sig0(ext[1+k]) + ext[k];
    end
  end

  always_comb begin
    state_n    = state;
    t_n        = t;
    done_n     = 1'b0;
    load_ready = (state == IDLE);
    w_valid    = (state == RUN);
    for (int unsigned i = 0; i < 16; i++) begin
      win_n[i] = win[i];
    end
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_n = RUN;
          t_n     = '0;
          for (int unsigned i = 0; i < 16; i++) begin
            win_n[i] = block_in[511-32*i -: 32];
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (w_ready) begin
          if (t == LAST_T) begin
            // Window and t are left untouched on the final beat so no
            // word past W[ROUNDS-1] ever reaches w_out.
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            t_n = t + STEP;
            for (int unsigned i = 0; i < 16; i++) begin
              win_n[i] = ext[i+WPC];
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      done  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else begin
      state <= state_n;
      t     <= t_n;
      done  <= done_n;
      for (int unsigned i = 0; i < 16; i++) begin
        win[i] <= win_n[i];
      end
    end
  end

  always_comb begin
    w_out = '0;
    for (int unsigned k = 0; k < WPC; k++) begin
      w_out[32*(WPC-1-k) +: 32] = win[k];
    end
  end

  assign w_round = t;

endmodule

// File: tb/tb_sha256_w_expander_param.sv
module tb_sha256_w_expander_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         abort;
  logic         w_ready;
  logic [511:0] block_in;
  int unsigned  sel;

  always #5 clk = ~clk;

  logic        lr0, lr1, lr2, lr3;
  logic        wv0, wv1, wv2, wv3;
  logic        dn0, dn1, dn2, dn3;
  logic [5:0]  wr0, wr1, wr2, wr3;
  logic [31:0]  wo0;
  logic [63:0]  wo1;
  logic [127:0] wo2;
  logic [31:0]  wo3;

  // d0: WPC=1/64, d1: WPC=2/64, d2: WPC=4/64, d3: WPC=1/16
  sha256_w_expander_param #(.WPC(1), .ROUNDS(64)) d0 (
    .clk(clk), .rst(rst), .load_valid(load_valid && sel == 0), .load_ready(lr0),
    .block_in(block_in), .abort(abort && sel == 0), .w_valid(wv0), .w_ready(w_ready),
    .w_out(wo0), .w_round(wr0), .done(dn0));
  sha256_w_expander_param #(.WPC(2), .ROUNDS(64)) d1 (
    .clk(clk), .rst(rst), .load_valid(load_valid && sel == 1), .load_ready(lr1),
    .block_in(block_in), .abort(abort && sel == 1), .w_valid(wv1), .w_ready(w_ready),
    .w_out(wo1), .w_round(wr1), .done(dn1));
  sha256_w_expander_param #(.WPC(4), .ROUNDS(64)) d2 (
    .clk(clk), .rst(rst), .load_valid(load_valid && sel == 2), .load_ready(lr2),
    .block_in(block_in), .abort(abort && sel == 2), .w_valid(wv2), .w_ready(w_ready),
    .w_out(wo2), .w_round(wr2), .done(dn2));
  sha256_w_expander_param #(.WPC(1), .ROUNDS(16)) d3 (
    .clk(clk), .rst(rst), .load_valid(load_valid && sel == 3), .load_ready(lr3),
    .block_in(block_in), .abort(abort && sel == 3), .w_valid(wv3), .w_ready(w_ready),
    .w_out(wo3), .w_round(wr3), .done(dn3));

  // Observed outputs of the selected instance, w_out left-aligned in 128 bits.
  logic         o_lr, o_wv, o_dn;
  logic [5:0]   o_wr;
  logic [127:0] o_wo;

  always_comb begin
    o_lr = 1'b0; o_wv = 1'b0; o_dn = 1'b0; o_wr = '0; o_wo = '0;
    case (sel)
      0: begin o_lr = lr0; o_wv = wv0; o_dn = dn0; o_wr = wr0; o_wo = {wo0, 96'b0}; end
      1: begin o_lr = lr1; o_wv = wv1; o_dn = dn1; o_wr = wr1; o_wo = {wo1, 64'b0}; end
      2: begin o_lr = lr2; o_wv = wv2; o_dn = dn2; o_wr = wr2; o_wo = wo2; end
      default: begin o_lr = lr3; o_wv = wv3; o_dn = dn3; o_wr = wr3; o_wo = {wo3, 96'b0}; end
    endcase
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] mw    [64];  // reference schedule
  logic [31:0] obs_w [64];  // words seen on transferred beats

  function automatic int wpc_of(input int unsigned s);
    return (s == 1) ? 2 : (s == 2) ? 4 : 1;
  endfunction

  function automatic int rounds_of(input int unsigned s);
    return (s == 3) ? 16 : 64;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic compute_model(input logic [511:0] b);
    for (int j = 0; j < 16; j++) mw[j] = b[511-32*j -: 32];
    for (int j = 16; j < 64; j++) begin
      mw[j] = (rotr(mw[j-2], 17) ^ rotr(mw[j-2], 19) ^ (mw[j-2] >> 10))
            + mw[j-7]
            + (rotr(mw[j-15], 7) ^ rotr(mw[j-15], 18) ^ (mw[j-15] >> 3))
            + mw[j-16];
    end
  endtask

  function automatic logic [127:0] exp_words(input int t, input int wpc);
    logic [127:0] e = '0;
    for (int k = 0; k < wpc; k++) e[127-32*k -: 32] = mw[t+k];
    return e;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (time %0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one block into instance s and consume it. w_ready is high with
  // probability pct percent. abort_at / rst_at (-1 = never) interrupt the
  // block when the beat at that round is presented.
  task automatic run_block(input int unsigned s, input logic [511:0] b, input int pct,
                           input int abort_at, input int rst_at, input bit idle_abort);
    int wpc, rounds, t, cycles;
    bit rdy;
    sel    = s;
    wpc    = wpc_of(s);
    rounds = rounds_of(s);
    compute_model(b);
    chk("load_ready_idle", 128'(o_lr), 128'(1));
    block_in   = b;
    load_valid = 1'b1;
    abort      = idle_abort;
    w_ready    = 1'b0;
    tick();
    load_valid = 1'b0;
    abort      = 1'b0;
    t = 0;
    cycles = 0;
    while (t < rounds) begin
      chk("w_valid_run", 128'(o_wv), 128'(1));
      chk("w_round", 128'(o_wr), 128'(t));
      chk("w_out", o_wo, exp_words(t, wpc));
      chk("load_ready_run", 128'(o_lr), 128'(0));
      chk("done_run", 128'(o_dn), 128'(0));
      if (t == abort_at) begin
        abort   = 1'b1;
        w_ready = 1'b1;
        tick();
        abort   = 1'b0;
        w_ready = 1'b0;
        chk("abort_w_valid", 128'(o_wv), 128'(0));
        chk("abort_done", 128'(o_dn), 128'(0));
        chk("abort_load_ready", 128'(o_lr), 128'(1));
        tick();
        chk("abort_no_done", 128'(o_dn), 128'(0));
        return;
      end
      if (t == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_w_valid", 128'(o_wv), 128'(0));
        chk("rst_w_out", o_wo, 128'(0));
        chk("rst_w_round", 128'(o_wr), 128'(0));
        chk("rst_done", 128'(o_dn), 128'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("rst_load_ready", 128'(o_lr), 128'(1));
        chk("rst_no_done", 128'(o_dn), 128'(0));
        chk("rst_w_valid_after", 128'(o_wv), 128'(0));
        return;
      end
      rdy = ($urandom_range(0, 99) < pct);
      w_ready = rdy;
      if (rdy) begin
        for (int k = 0; k < wpc; k++) obs_w[t+k] = o_wo[127-32*k -: 32];
      end
      tick();
      if (rdy) t += wpc;
      cycles++;
      if (cycles > 2000) begin
        checks++;
        errors++;
        $display("FAIL timeout: block on instance %0d stuck at round %0d", s, t);
        w_ready = 1'b0;
        return;
      end
    end
    w_ready = 1'b0;
    chk("done_pulse", 128'(o_dn), 128'(1));
    chk("end_w_valid", 128'(o_wv), 128'(0));
    chk("end_load_ready", 128'(o_lr), 128'(1));
    if (pct >= 100) chk("beat_cycles", 128'(cycles), 128'(rounds / wpc));
  endtask

  typedef struct {
    int unsigned  s;
    logic [511:0] blk;
    int           pct;
    int           abort_at;
    bit           idle_abort;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [511:0] abc_blk;
    logic [511:0] blk_a, blk_b;

    abc_blk = {32'h61626380, 448'b0, 32'h00000018};
    vecs[0] = '{s: 0, blk: abc_blk,      pct: 100, abort_at: -1, idle_abort: 1'b0};
    vecs[1] = '{s: 2, blk: abc_blk,      pct: 100, abort_at: -1, idle_abort: 1'b0};
    vecs[2] = '{s: 1, blk: rand_block(), pct: 50,  abort_at: -1, idle_abort: 1'b0};
    vecs[3] = '{s: 1, blk: rand_block(), pct: 50,  abort_at: -1, idle_abort: 1'b0};
    vecs[4] = '{s: 0, blk: rand_block(), pct: 100, abort_at: 20, idle_abort: 1'b0};
    vecs[5] = '{s: 0, blk: rand_block(), pct: 100, abort_at: -1, idle_abort: 1'b0};
    vecs[6] = '{s: 0, blk: rand_block(), pct: 70,  abort_at: -1, idle_abort: 1'b1};
    vecs[7] = '{s: 2, blk: rand_block(), pct: 60,  abort_at: -1, idle_abort: 1'b0};
    vecs[8] = '{s: 3, blk: rand_block(), pct: 100, abort_at: -1, idle_abort: 1'b0};

    rst = 1'b1; load_valid = 1'b0; abort = 1'b0; w_ready = 1'b0;
    block_in = '0; sel = 0;
    #1;
    for (int unsigned s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk("reset_w_valid", 128'(o_wv), 128'(0));
      chk("reset_done", 128'(o_dn), 128'(0));
      chk("reset_w_out", o_wo, 128'(0));
      chk("reset_w_round", 128'(o_wr), 128'(0));
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int unsigned s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk("reset_load_ready", 128'(o_lr), 128'(1));
    end

    for (int i = 0; i < 9; i++) begin
      run_block(vecs[i].s, vecs[i].blk, vecs[i].pct, vecs[i].abort_at, -1, vecs[i].idle_abort);
      if (i == 0) begin
        chk("abc_W16_wpc1", 128'(obs_w[16]), 128'(32'h61626380));
        chk("abc_W17_wpc1", 128'(obs_w[17]), 128'(32'h000F0000));
      end
      if (i == 1) begin
        chk("abc_W16_wpc4", 128'(obs_w[16]), 128'(32'h61626380));
        chk("abc_W17_wpc4", 128'(obs_w[17]), 128'(32'h000F0000));
      end
      tick();
      chk("done_single", 128'(o_dn), 128'(0));
    end

    // Reset in the middle of a block, then a clean block.
    run_block(0, rand_block(), 100, -1, 37, 1'b0);
    tick();
    chk("rst_still_no_done", 128'(o_dn), 128'(0));
    run_block(0, rand_block(), 100, -1, -1, 1'b0);
    tick();

    // ROUNDS=16 back-to-back: second load in the cycle done is high.
    blk_a = rand_block();
    blk_b = rand_block();
    run_block(3, blk_a, 100, -1, -1, 1'b0);
    run_block(3, blk_b, 100, -1, -1, 1'b0);
    tick();
    chk("b2b_done_single", 128'(o_dn), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
